// File: rtl/itcm_auto_load_ctrl_if.sv
// AHB read and ITCM write bundle for the ITCM auto-load controller.
`timescale 1ns/1ps
interface itcm_auto_load_ctrl_if;
  logic        al_ahb_access;
  logic [31:0] al_ahb_addr;
  logic [31:0] al_ahb_read_data;
  logic        al_ahb_read_data_valid;
  logic        itcm_al_wr_en;
  logic [31:0] itcm_al_addr;
  logic [31:0] itcm_al_wdata;

  modport master (
    output al_ahb_access, al_ahb_addr,
    input  al_ahb_read_data, al_ahb_read_data_valid,
    output itcm_al_wr_en, itcm_al_addr, itcm_al_wdata
  );

  modport slave (
    input  al_ahb_access, al_ahb_addr,
    output al_ahb_read_data, al_ahb_read_data_valid,
    input  itcm_al_wr_en, itcm_al_addr, itcm_al_wdata
  );
endinterface

// File: rtl/itcm_auto_load_ctrl.sv
// Copies NUM_WORDS words from AHB space into ITCM after reset or on restart.
// Optional running checksum of written words: define KRV_ITCM_AL_CHECKSUM_EN.
`timescale 1ns/1ps
module itcm_auto_load_ctrl #(
  parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
  parameter logic [31:0] DST_BASE  = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 4096
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  input  logic                 al_restart,
  itcm_auto_load_ctrl_if.master bus,
  output logic                 itcm_auto_load,
  output logic                 al_done
`ifdef KRV_ITCM_AL_CHECKSUM_EN
  ,
  output logic [31:0]          al_checksum,
  output logic                 al_checksum_valid
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {START, FETCH, WRITE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [CNT_W-1:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

  // Outputs are loaded together with the state they belong to, so they are valid for that whole state.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state              <= START;
      cnt                <= '0;
      bus.al_ahb_access  <= 1'b0;
      bus.al_ahb_addr    <= '0;
      bus.itcm_al_wr_en  <= 1'b0;
      bus.itcm_al_addr   <= '0;
      bus.itcm_al_wdata  <= '0;
      al_done            <= 1'b0;
      itcm_auto_load     <= 1'b1;
    end else begin
      al_done <= 1'b0;
      case (state)
        START: begin
          cnt               <= '0;
          state             <= FETCH;
          bus.al_ahb_access <= 1'b1;
          bus.al_ahb_addr   <= SRC_BASE;
        end
        FETCH: begin
          if (bus.al_ahb_read_data_valid) begin
            state             <= WRITE;
            bus.al_ahb_access <= 1'b0;
            bus.itcm_al_wdata <= bus.al_ahb_read_data;
            bus.itcm_al_addr  <= word_addr(DST_BASE, cnt);
            bus.itcm_al_wr_en <= 1'b1;
          end
        end
        WRITE: begin
          bus.itcm_al_wr_en <= 1'b0;
          if (cnt == LAST_IDX) begin
            state          <= DONE;
            al_done        <= 1'b1;
            itcm_auto_load <= 1'b0;
          end else begin
            cnt               <= cnt_inc;
            state             <= FETCH;
            bus.al_ahb_access <= 1'b1;
            bus.al_ahb_addr   <= word_addr(SRC_BASE, cnt_inc);
          end
        end
        DONE: begin
          if (al_restart) begin
            state          <= START;
            itcm_auto_load <= 1'b1;
          end
        end
        default: state <= START;
      endcase
    end
  end

`ifdef KRV_ITCM_AL_CHECKSUM_EN
  // Sum of every word written this run; flagged valid for as long as the FSM sits in DONE.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      al_checksum       <= '0;
      al_checksum_valid <= 1'b0;
    end else begin
      case (state)
        START:   al_checksum <= '0;
        WRITE:   al_checksum <= al_checksum + bus.itcm_al_wdata;
        default: al_checksum <= al_checksum;
      endcase
      al_checksum_valid <= ((state == WRITE) && (cnt == LAST_IDX)) ||
                           ((state == DONE) && !al_restart);
    end
  end
`endif

endmodule

// File: tb/tb_itcm_auto_load_ctrl.sv
// Directed bench for itcm_auto_load_ctrl: 4-word and 1-word instances, programmable AHB wait states.
`timescale 1ns/1ps
module tb_itcm_auto_load_ctrl;

  logic cpu_clk = 1'b0;
  logic cpu_rstn = 1'b1;
  logic al_restart = 1'b0;
  logic al_restart1 = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  itcm_auto_load_ctrl_if bus ();
  itcm_auto_load_ctrl_if bus1 ();

  logic itcm_auto_load, al_done, itcm_auto_load1, al_done1;
`ifdef KRV_ITCM_AL_CHECKSUM_EN
  logic [31:0] al_checksum, al_checksum1;
  logic        al_checksum_valid, al_checksum_valid1;
`endif

  itcm_auto_load_ctrl #(.SRC_BASE(32'h2000_0000), .DST_BASE(32'h0), .NUM_WORDS(4)) u_dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .al_restart(al_restart), .bus(bus),
    .itcm_auto_load(itcm_auto_load), .al_done(al_done)
`ifdef KRV_ITCM_AL_CHECKSUM_EN
    , .al_checksum(al_checksum), .al_checksum_valid(al_checksum_valid)
`endif
  );

  itcm_auto_load_ctrl #(.SRC_BASE(32'h2000_0000), .DST_BASE(32'h0), .NUM_WORDS(1)) u_dut1 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .al_restart(al_restart1), .bus(bus1),
    .itcm_auto_load(itcm_auto_load1), .al_done(al_done1)
`ifdef KRV_ITCM_AL_CHECKSUM_EN
    , .al_checksum(al_checksum1), .al_checksum_valid(al_checksum_valid1)
`endif
  );

  // AHB slave: word index from address bits, valid after delay[word] extra cycles of access
  logic [31:0] mem [4];
  int          delay [4];
  int          acc_cycles = 0;
  logic [1:0]  widx;

  assign widx = bus.al_ahb_addr[3:2];
  assign bus.al_ahb_read_data       = mem[widx];
  assign bus.al_ahb_read_data_valid = bus.al_ahb_access && (acc_cycles == delay[widx]);

  always @(posedge cpu_clk) begin
    if (bus.al_ahb_access && !bus.al_ahb_read_data_valid) acc_cycles <= acc_cycles + 1;
    else acc_cycles <= 0;
  end

  assign bus1.al_ahb_read_data       = 32'hA5A5_0001;
  assign bus1.al_ahb_read_data_valid = bus1.al_ahb_access;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          done_k, done_cnt, wr_cnt, fall_k, acc8_cnt, done1_k, wr1_cnt;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  logic [31:0] first_fetch;
  logic        ff_seen;

  // Sample n cycles after the current one; k=1 is the cycle after the next rising edge.
  task automatic observe(input int n, input int restart_k);
    done_k = -1; done_cnt = 0; wr_cnt = 0; fall_k = -1; acc8_cnt = 0;
    done1_k = -1; wr1_cnt = 0; ff_seen = 1'b0; first_fetch = '1;
    for (int k = 1; k <= n; k++) begin
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      al_restart = 1'b0;
      if (bus.al_ahb_access && !ff_seen) begin
        first_fetch = bus.al_ahb_addr;
        ff_seen = 1'b1;
      end
      if (bus.al_ahb_access && bus.al_ahb_addr == 32'h2000_0008) acc8_cnt++;
      if (bus.itcm_al_wr_en) begin
        if (wr_cnt < 8) begin
          wr_addr[wr_cnt] = bus.itcm_al_addr;
          wr_data[wr_cnt] = bus.itcm_al_wdata;
        end
        wr_cnt++;
      end
      if (al_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (!itcm_auto_load && fall_k < 0) fall_k = k;
      if (bus1.itcm_al_wr_en) wr1_cnt++;
      if (al_done1 && done1_k < 0) done1_k = k;
      if (k == restart_k) al_restart = 1'b1;
    end
    al_restart = 1'b0;
  endtask

  // Called at a falling edge while in DONE; returns at the falling edge of the START cycle.
  task automatic restart_run();
    al_restart  = 1'b1;
    al_restart1 = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    al_restart  = 1'b0;
    al_restart1 = 1'b0;
  endtask

  initial begin
    mem   = '{32'h11, 32'h22, 32'h33, 32'h44};
    delay = '{0, 0, 0, 0};

    #2 cpu_rstn = 1'b0;
    @(negedge cpu_clk);
    check("rst_access", 32'(bus.al_ahb_access), 32'd0);
    check("rst_wr_en", 32'(bus.itcm_al_wr_en), 32'd0);
    check("rst_done", 32'(al_done), 32'd0);
    check("rst_auto_load", 32'(itcm_auto_load), 32'd1);
    check("rst_auto_load1", 32'(itcm_auto_load1), 32'd1);
`ifdef KRV_ITCM_AL_CHECKSUM_EN
    check("rst_cks_valid", 32'(al_checksum_valid), 32'd0);
`endif
    cpu_rstn = 1'b1;

    // zero-wait load; restart during FETCH must be ignored
    observe(14, 3);
    check("t1_first_fetch", first_fetch, 32'h2000_0000);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_wr_addr%0d", i), wr_addr[i], 32'(4 * i));
      check($sformatf("t1_wr_data%0d", i), wr_data[i], 32'(32'h11 * (i + 1)));
    end
    check("t1_done_k", 32'(done_k), 32'd9);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_fall_k", 32'(fall_k), 32'd9);
    check("t1_dut1_done_k", 32'(done1_k), 32'd3);
    check("t1_dut1_wr_cnt", 32'(wr1_cnt), 32'd1);
    check("t1_auto_load_done", 32'(itcm_auto_load), 32'd0);
`ifdef KRV_ITCM_AL_CHECKSUM_EN
    check("t1_cks", al_checksum, 32'h0000_00AA);
    check("t1_cks_valid", 32'(al_checksum_valid), 32'd1);
`endif

    // restart from DONE with 3 wait cycles on word 2
    delay[2] = 3;
    restart_run();
    check("t2_auto_load_start", 32'(itcm_auto_load), 32'd1);
    observe(14, 0);
    check("t2_acc8_cnt", 32'(acc8_cnt), 32'd4);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t2_wr_addr2", wr_addr[2], 32'h8);
    check("t2_wr_data2", wr_data[2], 32'h33);
    check("t2_done_k", 32'(done_k), 32'd12);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // reset while writing word 2
    delay[2] = 0;
    restart_run();
    observe(6, 0);
    check("t3_wr_cnt_pre", 32'(wr_cnt), 32'd3);
    check("t3_wr_en_pre", 32'(bus.itcm_al_wr_en), 32'd1);
    check("t3_wr_addr_pre", bus.itcm_al_addr, 32'h8);
    cpu_rstn = 1'b0;
    #1;
    check("t3_rst_wr_en", 32'(bus.itcm_al_wr_en), 32'd0);
    check("t3_rst_access", 32'(bus.al_ahb_access), 32'd0);
    check("t3_rst_auto_load", 32'(itcm_auto_load), 32'd1);
    check("t3_rst_done", 32'(al_done), 32'd0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    observe(12, 0);
    check("t3_first_fetch", first_fetch, 32'h2000_0000);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t3_wr_addr0", wr_addr[0], 32'h0);
    check("t3_done_k", 32'(done_k), 32'd9);

`ifdef KRV_ITCM_AL_CHECKSUM_EN
    // checksum wraps modulo 2^32
    mem = '{32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0};
    restart_run();
    observe(4, 0);
    check("t4_cks_valid_run", 32'(al_checksum_valid), 32'd0);
    observe(8, 0);
    check("t4_cks", al_checksum, 32'h1);
    check("t4_cks_valid", 32'(al_checksum_valid), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
